// File: rtl/branch_target_buffer_pkg.sv
// Shared BTB types and constants.
// Entry layout, index/tag widths, counter encodings.
package branch_target_buffer_pkg;

  localparam int BTB_IDX_W = 2;
  localparam int BTB_TAG_W = 32 - BTB_IDX_W - 2;
  localparam int BTB_ENTRIES = 1 << BTB_IDX_W;

  localparam logic [1:0] CNT_WEAK_NT = 2'b01;
  localparam logic [1:0] CNT_WEAK_T = 2'b10;

  typedef logic [31:0] word_t;
  typedef logic [BTB_IDX_W-1:0] btb_idx_t;
  typedef logic [BTB_TAG_W-1:0] btb_tag_t;

  typedef struct packed {
    logic     valid;
    btb_tag_t tag;
    word_t    target;
    logic [1:0] cnt;
  } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_if.sv
// BTB fetch-lookup and mem-stage update bundle.
// master: pipeline side; slave: BTB side.
interface branch_target_buffer_if;
  import branch_target_buffer_pkg::*;

  word_t    fetch_pc;
  logic     btb_taken;
  word_t    btb_target;
  btb_idx_t btb_index;

  logic     upd_en;
  word_t    upd_pc;
  btb_idx_t upd_index;
  logic     upd_taken;
  word_t    upd_target;
  logic     upd_pred_tk;
  word_t    upd_pred_tgt;
  logic     mispredict;

  modport master (
    output fetch_pc,
    output upd_en,
    output upd_pc,
    output upd_index,
    output upd_taken,
    output upd_target,
    output upd_pred_tk,
    output upd_pred_tgt,
    input  btb_taken,
    input  btb_target,
    input  btb_index,
    input  mispredict
  );

  modport slave (
    input  fetch_pc,
    input  upd_en,
    input  upd_pc,
    input  upd_index,
    input  upd_taken,
    input  upd_target,
    input  upd_pred_tk,
    input  upd_pred_tgt,
    output btb_taken,
    output btb_target,
    output btb_index,
    output mispredict
  );

endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating counter next-state.
// Ports: cnt, inc/dec/load (mutually exclusive), load_val -> nxt.
module sat_counter2 (
  input  logic [1:0] cnt,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [1:0] load_val,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cnt;
    unique case (1'b1)
      load: nxt = load_val;
      inc: begin
        if (cnt != 2'b11) nxt = cnt + 2'd1;
      end
      dec: begin
        if (cnt != 2'b00) nxt = cnt - 2'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters.
// Ports: CLK, nRST, bus (slave), br_count, mispred_count.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter logic [1:0] CNT_INIT = CNT_WEAK_NT
) (
  input  logic CLK,
  input  logic nRST,
  branch_target_buffer_if.slave bus,
  output word_t br_count,
  output word_t mispred_count
);

  btb_entry_t tbl [BTB_ENTRIES];

  logic [1:0] cnt_nxt [BTB_ENTRIES];
  logic [BTB_ENTRIES-1:0] c_inc;
  logic [BTB_ENTRIES-1:0] c_dec;
  logic [BTB_ENTRIES-1:0] c_load;

  btb_idx_t   f_idx;
  btb_entry_t f_ent;
  logic       f_hit;
  btb_entry_t u_ent;
  logic       u_hit;
  logic       misp;

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{bus.fetch_pc[1:0], bus.upd_pc[1:0]};

  always_comb begin
    f_idx = bus.fetch_pc[BTB_IDX_W+1:2];
    f_ent = tbl[f_idx];
    f_hit = f_ent.valid &&
            (f_ent.tag == bus.fetch_pc[31:BTB_IDX_W+2]);
  end

  assign bus.btb_index  = f_idx;
  assign bus.btb_taken  = f_hit & f_ent.cnt[1];
  assign bus.btb_target = f_hit ? f_ent.target : '0;

  always_comb begin
    u_ent = tbl[bus.upd_index];
    u_hit = u_ent.valid &&
            (u_ent.tag == bus.upd_pc[31:BTB_IDX_W+2]);
    misp  = bus.upd_en &&
            ((bus.upd_taken != bus.upd_pred_tk) ||
             (bus.upd_taken && bus.upd_pred_tk &&
              (bus.upd_target != bus.upd_pred_tgt)));
  end

  assign bus.mispredict = misp;

  // Only the addressed entry trains; a not-taken miss leaves
  // the table untouched so cold branches don't evict.
  always_comb begin
    c_inc  = '0;
    c_dec  = '0;
    c_load = '0;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      if (bus.upd_en && (bus.upd_index == btb_idx_t'(i))) begin
        c_inc[i]  = u_hit & bus.upd_taken;
        c_dec[i]  = u_hit & ~bus.upd_taken;
        c_load[i] = ~u_hit & bus.upd_taken;
      end
    end
  end

  for (genvar e = 0; e < BTB_ENTRIES; e++) begin : g_cnt
    sat_counter2 u_cnt (
      .cnt      (tbl[e].cnt),
      .inc      (c_inc[e]),
      .dec      (c_dec[e]),
      .load     (c_load[e]),
      .load_val (CNT_WEAK_T),
      .nxt      (cnt_nxt[e])
    );
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tbl[i].valid  <= 1'b0;
        tbl[i].tag    <= '0;
        tbl[i].target <= '0;
        tbl[i].cnt    <= CNT_INIT;
      end
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tbl[i].cnt <= cnt_nxt[i];
        if (c_load[i]) begin
          tbl[i].valid  <= 1'b1;
          tbl[i].tag    <= bus.upd_pc[31:BTB_IDX_W+2];
          tbl[i].target <= bus.upd_target;
        end else if (c_inc[i]) begin
          tbl[i].target <= bus.upd_target;
        end
      end
      br_count      <= br_count + 32'(bus.upd_en);
      mispred_count <= mispred_count + 32'(misp);
    end
  end

  idx_matches_pc: assert property (
    @(posedge CLK) disable iff (!nRST)
    bus.upd_en |->
      (bus.upd_index == bus.upd_pc[BTB_IDX_W+1:2])
  );

endmodule
